lcd_ctrl: RTL

Hardware HD44780 write engine for the DE2 character LCD. It replaces software bit-banging of the LCD register with a byte-level valid/ready request port. It runs the power-on initialisation sequence autonomously, then turns each accepted byte into a correctly timed LCD write cycle: setup, EN pulse, hold, and execution wait. It sits between the LSU's LCD I/O slot and the top-level `LCD_*` pins.

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_timer.sv | 29 ++
 rtl/lcd_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write engine: FSM state encoding,
// the power-on init command ROM, command constants and small helpers.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } lcd_state_e;

    localparam int INIT_LEN = 7;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift

    // Entry 0 sits in the low byte. Function set is repeated four times so
    // the controller syncs to 8-bit mode regardless of its power-on state.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        CMD_ENTRY, CMD_CLEAR, CMD_DISP_ON,
        CMD_FUNC_SET, CMD_FUNC_SET, CMD_FUNC_SET, CMD_FUNC_SET
    };

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed state of the LCD engine.
//   clk_i     : clock
//   load_i    : load value_i this cycle (takes priority over counting)
//   value_i   : N-1 for a state that must last N cycles
//   expired_o : counter has reached zero (last cycle of the current state)
module lcd_timer
    import lcd_pkg::*;
#(
    parameter int W = 20
) (
    input  logic         clk_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    // No reset of its own: the top asserts load_i during reset.
    always_ff @(posedge clk_i) begin
        if (load_i)
            cnt_q <= value_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write engine for the DE2 character LCD. Runs the power-on init
// sequence, then turns each accepted byte into a timed LCD write cycle
// (setup, EN pulse, hold, execution wait).
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_valid_i/ready_o   : byte request handshake, transfer on valid && ready
//   req_rs_i, req_data_i  : 0 = command / 1 = data, and the byte
//   init_done_o           : sticky, init sequence finished
//   busy_o                : engine not idle (always !req_ready_o)
//   lcd_data_o, lcd_rw_o, lcd_rs_o, lcd_en_o, lcd_on_o : LCD pins
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_SETUP      = 2,
    parameter int T_PULSE      = 12,
    parameter int T_HOLD       = 2,
    parameter int T_EXEC       = 1850,
    parameter int T_CLEAR      = 76000,
    parameter int T_POWERUP    = 750000,
    parameter int T_INIT_LONG  = 205000,
    parameter int T_INIT_SHORT = 5000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rs_i,
    input  logic [7:0] req_data_i,
    output logic       init_done_o,
    output logic       busy_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rw_o,
    output logic       lcd_rs_o,
    output logic       lcd_en_o,
    output logic       lcd_on_o
);

    // Counter holds N-1 of the longest state, so log2(max) bits suffice.
    localparam int CNT_MAX = max2(max2(max2(T_SETUP, T_PULSE), max2(T_HOLD, T_EXEC)),
                                  max2(max2(T_CLEAR, T_POWERUP), max2(T_INIT_LONG, T_INIT_SHORT)));
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    lcd_state_e       state_q, state_n;
    logic [2:0]       init_idx_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic [CNT_W-1:0] wait_val;
    logic             expired;
    logic             accept;
    logic             init_last;

    lcd_timer #(.W(CNT_W)) u_timer (
        .clk_i    (clk_i),
        .load_i   (tmr_load),
        .value_i  (tmr_value),
        .expired_o(expired)
    );

    assign accept    = (state_q == ST_IDLE) && req_valid_i;
    assign init_last = (init_idx_q == 3'(INIT_LEN - 1));
    assign lcd_rw_o  = 1'b0;

    // Execution wait for the write currently on the bus. The first two init
    // entries have their own datasheet waits; only valid while still in init.
    always_comb begin
        wait_val = CNT_W'(T_EXEC - 1);
        if (!init_done_o && init_idx_q == 3'd0)
            wait_val = CNT_W'(T_INIT_LONG - 1);
        else if (!init_done_o && init_idx_q == 3'd1)
            wait_val = CNT_W'(T_INIT_SHORT - 1);
        else if (is_slow_cmd(lcd_rs_o, lcd_data_o))
            wait_val = CNT_W'(T_CLEAR - 1);
    end

    always_comb begin
        state_n   = state_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state_q)
            ST_POWERUP: begin
                if (expired) state_n = ST_INIT_LOAD;
            end
            ST_INIT_LOAD: begin
                state_n   = ST_SETUP;
                tmr_load  = 1'b1;
                tmr_value = CNT_W'(T_SETUP - 1);
            end
            ST_IDLE: begin
                if (accept) begin
                    state_n   = ST_SETUP;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(T_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (expired) begin
                    state_n   = ST_PULSE;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(T_PULSE - 1);
                end
            end
            ST_PULSE: begin
                if (expired) begin
                    state_n   = ST_HOLD;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(T_HOLD - 1);
                end
            end
            ST_HOLD: begin
                if (expired) begin
                    state_n   = ST_WAIT;
                    tmr_load  = 1'b1;
                    tmr_value = wait_val;
                end
            end
            ST_WAIT: begin
                if (expired)
                    state_n = (!init_done_o && !init_last) ? ST_INIT_LOAD : ST_IDLE;
            end
            default: state_n = ST_POWERUP;
        endcase
        // Reset re-arms the power-up wait so the init sequence reruns in full.
        if (rst_i) begin
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(T_POWERUP - 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_POWERUP;
            init_idx_q <= '0;
        end else begin
            state_q <= state_n;
            if (state_q == ST_WAIT && expired && !init_done_o && !init_last)
                init_idx_q <= init_idx_q + 3'd1;
        end
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lcd_data_o  <= '0;
            lcd_rs_o    <= 1'b0;
            lcd_en_o    <= 1'b0;
            lcd_on_o    <= 1'b0;
            req_ready_o <= 1'b0;
            init_done_o <= 1'b0;
            busy_o      <= 1'b1;
        end else begin
            lcd_on_o    <= 1'b1;
            lcd_en_o    <= (state_n == ST_PULSE);
            req_ready_o <= (state_n == ST_IDLE);
            busy_o      <= (state_n != ST_IDLE);
            init_done_o <= init_done_o | (state_n == ST_IDLE);
            // RS/DATA change only at write start, so they stay put through
            // PULSE, HOLD and WAIT.
            if (state_q == ST_INIT_LOAD) begin
                lcd_data_o <= INIT_ROM[init_idx_q];
                lcd_rs_o   <= 1'b0;
            end else if (accept) begin
                lcd_data_o <= req_data_i;
                lcd_rs_o   <= req_rs_i;
            end
        end
    end

endmodule
